// File: rtl/ring_decoder.sv
// ring_decoder
//   Receive-side checker/decoder for a one-hot ring-counter stream. It
//   converts each sampled word to a binary index. After LOCK_CNT
//   consecutive correct rotate-left advances it locks onto the sequence.
//   It flags illegal codes, sequence breaks and wrap-arounds, and keeps a
//   saturating error count.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   en          sample strobe; ring_in is evaluated only when en=1
//   ring_in     ring word under test (WIDTH bits)
//   clr_err     synchronous clear of err_cnt; wins over an increment
//   idx         binary position of the set bit in the last legal sample
//   idx_vld     pulse: idx was updated from a legal sample
//   onehot_err  pulse: the sample was not exactly one-hot (all-zero included)
//   seq_err     pulse: a legal sample broke the sequence while locked
//   wrap        pulse: locked advance from bit WIDTH-1 to bit 0
//   locked      level: state machine is in LOCKED
//   err_cnt     saturating count of onehot_err / seq_err events
//
// Build option
//   RING_DEC_STALL_EN: a legal sample equal to the previous legal sample is a
//   stall. It pulses idx_vld and changes nothing else. Without the macro,
//   a repeated word is an ordinary mismatch.

module ring_decoder #(
  parameter int WIDTH    = 8,
  parameter int IDXW     = 3,
  parameter int ERRW     = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] ring_in,
  input  logic             clr_err,
  output logic [IDXW-1:0]  idx,
  output logic             idx_vld,
  output logic             onehot_err,
  output logic             seq_err,
  output logic             wrap,
  output logic             locked,
  output logic [ERRW-1:0]  err_cnt
);

  localparam int GW = $clog2(LOCK_CNT + 1);

  typedef enum logic {
    S_SEARCH = 1'b0,
    S_LOCKED = 1'b1
  } state_t;

  state_t           r_state, w_state_next;
  logic [GW-1:0]    r_good_cnt, w_good_next;
  logic [WIDTH-1:0] r_prev, w_prev_next;
  logic             r_prev_vld, w_prev_vld_next;
  logic [IDXW-1:0]  r_idx, w_idx_next;
  logic             r_idx_vld, w_idx_vld_next;
  logic             r_onehot_err, w_onehot_next;
  logic             r_seq_err, w_seq_next;
  logic             r_wrap, w_wrap_next;
  logic [ERRW-1:0]  r_err_cnt;

  logic             w_legal;
  logic [IDXW-1:0]  w_idx;
  logic [WIDTH-1:0] w_expected;
  logic             w_match;
  logic             w_stall;
  logic [GW-1:0]    w_good_inc;

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves zero.
  assign w_legal = (ring_in != '0) &&
                   ((ring_in & (ring_in - {{(WIDTH-1){1'b0}}, 1'b1})) == '0);

  // OR of the bit positions; exact whenever the word is one-hot.
  always_comb begin
    w_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (ring_in[i]) w_idx = w_idx | IDXW'(i);
    end
  end

  assign w_expected = {r_prev[WIDTH-2:0], r_prev[WIDTH-1]};
  assign w_match    = r_prev_vld && (ring_in == w_expected);
  assign w_good_inc = r_good_cnt + GW'(1);

`ifdef RING_DEC_STALL_EN
  assign w_stall = r_prev_vld && (ring_in == r_prev);
`else
  assign w_stall = 1'b0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    w_state_next    = r_state;
    w_good_next     = r_good_cnt;
    w_prev_next     = r_prev;
    w_prev_vld_next = r_prev_vld;
    w_idx_next      = r_idx;
    w_idx_vld_next  = 1'b0;
    w_onehot_next   = 1'b0;
    w_seq_next      = 1'b0;
    w_wrap_next     = 1'b0;

    if (en) begin
      if (!w_legal) begin
        w_onehot_next   = 1'b1;
        w_prev_vld_next = 1'b0;
        w_good_next     = '0;
        w_state_next    = S_SEARCH;
      end else begin
        w_idx_next      = w_idx;
        w_idx_vld_next  = 1'b1;
        w_prev_next     = ring_in;
        w_prev_vld_next = 1'b1;
        if (!w_stall) begin
          if (r_state == S_SEARCH) begin
            if (w_match) begin
              if (w_good_inc == GW'(LOCK_CNT)) begin
                w_state_next = S_LOCKED;
                w_good_next  = '0;
              end else begin
                w_good_next = w_good_inc;
              end
            end else begin
              // Mismatch or first sample after invalidation: just re-seed.
              w_good_next = '0;
            end
          end else begin
            if (w_match) begin
              w_wrap_next = r_prev[WIDTH-1];
            end else begin
              w_seq_next   = 1'b1;
              w_state_next = S_SEARCH;
              w_good_next  = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_SEARCH;
      r_good_cnt   <= '0;
      r_prev       <= '0;
      r_prev_vld   <= 1'b0;
      r_idx        <= '0;
      r_idx_vld    <= 1'b0;
      r_onehot_err <= 1'b0;
      r_seq_err    <= 1'b0;
      r_wrap       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_good_cnt   <= w_good_next;
      r_prev       <= w_prev_next;
      r_prev_vld   <= w_prev_vld_next;
      r_idx        <= w_idx_next;
      r_idx_vld    <= w_idx_vld_next;
      r_onehot_err <= w_onehot_next;
      r_seq_err    <= w_seq_next;
      r_wrap       <= w_wrap_next;
    end
  end

  // Counts on the same edge the error pulse is registered, so err_cnt and
  // the pulse become visible together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (clr_err) begin
      r_err_cnt <= '0;
    end else if ((w_onehot_next || w_seq_next) && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + ERRW'(1);
    end
  end

  assign idx        = r_idx;
  assign idx_vld    = r_idx_vld;
  assign onehot_err = r_onehot_err;
  assign seq_err    = r_seq_err;
  assign wrap       = r_wrap;
  assign locked     = (r_state == S_LOCKED);
  assign err_cnt    = r_err_cnt;

endmodule
